// File: rtl/arbitro_vc_rr_if.sv
// Bundle between the virtual-channel FIFOs, the arbiter and the destination FIFOs.
// Handshake: the VC FIFOs are first-word-fall-through, so vc_data[i] is valid
// whenever vc_empty[i] is low. A one-cycle vc_pop[i] consumes that word in the
// same cycle. dest_almost_full[d] high means destination d cannot accept a new
// grant this cycle; dest_push[d] is a one-cycle write strobe carrying dest_data[d].
interface arbitro_vc_rr_if #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int CNT_W    = 8
);
  logic [NUM_VC*DATA_W-1:0]   vc_data;
  logic [NUM_VC-1:0]          vc_empty;
  logic [NUM_DEST-1:0]        dest_almost_full;
  logic [NUM_VC-1:0]          vc_pop;
  logic [NUM_DEST*DATA_W-1:0] dest_data;
  logic [NUM_DEST-1:0]        dest_push;
  logic [NUM_DEST*CNT_W-1:0]  push_cnt;

  // FIFO side: feeds words and back-pressure, observes pops and pushes
  modport master (
    output vc_data, vc_empty, dest_almost_full,
    input  vc_pop, dest_data, dest_push, push_cnt
  );

  // Arbiter side
  modport slave (
    input  vc_data, vc_empty, dest_almost_full,
    output vc_pop, dest_data, dest_push, push_cnt
  );
endinterface

// File: rtl/arbitro_vc_rr.sv
// Virtual-channel arbiter: picks at most one non-empty VC per cycle whose
// destination is not almost full, pops it, and pushes the word to its
// destination one cycle later. MODE 0 is fixed priority, MODE 1 is round robin
// with bursts of up to BURST consecutive grants.
module arbitro_vc_rr #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int DEST_LSB = 4,
  parameter int MODE     = 1,
  parameter int BURST    = 2,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           reset,
  arbitro_vc_rr_if.slave bus
);
  localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int BC_W   = 4;

  logic [VC_W-1:0]            owner_q, owner_d;
  logic                       owner_vld_q, owner_vld_d;
  logic [BC_W-1:0]            burst_q, burst_d;
  logic [NUM_DEST*DATA_W-1:0] dest_data_q, dest_data_d;
  logic [NUM_DEST-1:0]        dest_push_q, dest_push_d;
  logic [NUM_DEST*CNT_W-1:0]  push_cnt_q, push_cnt_d;

  logic [DEST_W-1:0] vc_dest [NUM_VC];
  logic [NUM_VC-1:0] elig;
  logic              gnt_vld;
  logic [VC_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_word;
  logic [DEST_W-1:0] gnt_dest;

  // Destination of each head word and whether that VC may be served now
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      vc_dest[i] = bus.vc_data[i*DATA_W + DEST_LSB +: DEST_W];
      elig[i]    = !bus.vc_empty[i] && !bus.dest_almost_full[vc_dest[i]];
    end
  end

  // Grant selection. Loops run from the lowest-preference candidate upward so
  // the last hit is the winner. After reset there is no owner yet, so the
  // first grant searches from owner+1 and always starts a fresh burst.
  always_comb begin
    int j;
    j        = 0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_word = '0;
    gnt_dest = '0;
    if (MODE == 0) begin
      for (int i = NUM_VC - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = VC_W'(i);
        end
      end
    end else if (owner_vld_q && elig[owner_q] && (burst_q < BC_W'(BURST - 1))) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int k = NUM_VC; k >= 1; k--) begin
        j = int'(owner_q) + k;
        if (j >= NUM_VC) j = j - NUM_VC;
        if (elig[j[VC_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = j[VC_W-1:0];
        end
      end
    end
    // A grant computed while reset is high is thrown away
    if (reset) gnt_vld = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (gnt_idx == VC_W'(i)) begin
        gnt_word = bus.vc_data[i*DATA_W +: DATA_W];
        gnt_dest = vc_dest[i];
      end
    end
  end

  // Next owner/burst state and registered destination outputs
  always_comb begin
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    burst_d     = burst_q;
    dest_data_d = '0;
    dest_push_d = '0;
    push_cnt_d  = push_cnt_q;
    if (gnt_vld) begin
      owner_d     = gnt_idx;
      owner_vld_d = 1'b1;
      // burst_q saturates at BURST-1: any larger value decides the same way
      if (owner_vld_q && (gnt_idx == owner_q)) begin
        if (burst_q < BC_W'(BURST - 1)) burst_d = burst_q + 1'b1;
      end else begin
        burst_d = '0;
      end
      for (int d = 0; d < NUM_DEST; d++) begin
        if (gnt_dest == DEST_W'(d)) begin
          dest_data_d[d*DATA_W +: DATA_W] = gnt_word;
          dest_push_d[d]                  = 1'b1;
          push_cnt_d[d*CNT_W +: CNT_W]    = push_cnt_q[d*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      burst_q     <= '0;
      dest_data_q <= '0;
      dest_push_q <= '0;
      push_cnt_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      burst_q     <= burst_d;
      dest_data_q <= dest_data_d;
      dest_push_q <= dest_push_d;
      push_cnt_q  <= push_cnt_d;
    end
  end

  assign bus.vc_pop    = gnt_vld ? (NUM_VC'(1) << gnt_idx) : '0;
  assign bus.dest_data = dest_data_q;
  assign bus.dest_push = dest_push_q;
  assign bus.push_cnt  = push_cnt_q;
endmodule

// File: tb/tb_arbitro_vc_rr.sv
// Bench for arbitro_vc_rr: a round-robin instance (bus1) driven from modelled
// VC queues with a reference arbiter, and a fixed-priority instance (bus0).
module tb_arbitro_vc_rr;
  localparam int EW = 2 + 12 + 16;

  logic clk;
  logic reset;

  arbitro_vc_rr_if #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .CNT_W(8)) bus1 ();
  arbitro_vc_rr_if #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .CNT_W(8)) bus0 ();

  arbitro_vc_rr #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .DEST_LSB(4), .MODE(1),
                  .BURST(2), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  arbitro_vc_rr #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .DEST_LSB(4), .MODE(0),
                  .BURST(2), .CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench-side VC FIFOs, back-pressure and reference state
  logic [5:0]    q0[$];
  logic [5:0]    q1[$];
  logic [1:0]    af;
  logic [EW-1:0] exp_q[$];
  int            gnt_log[$];
  int            m_owner;
  bit            m_vld;
  int            m_burst;
  logic [7:0]    m_cnt0, m_cnt1;
  int            checks = 0;
  int            errors = 0;

  function automatic int ref_grant(input logic [1:0] elig);
    int idx;
    if (m_vld && elig[m_owner[0]] && (m_burst < 1)) return m_owner;
    for (int k = 1; k <= 2; k++) begin
      idx = (m_owner + k) % 2;
      if (elig[idx[0]]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    bus1.vc_data          = {(q1.size() > 0) ? q1[0] : 6'h00, (q0.size() > 0) ? q0[0] : 6'h00};
    bus1.vc_empty         = {q1.size() == 0, q0.size() == 0};
    bus1.dest_almost_full = af;
  endtask

  // One cycle on the round-robin instance: drive, check, model, advance
  task automatic step(input bit rst);
    logic [1:0]    elig;
    logic [1:0]    exp_pop;
    logic [EW-1:0] e;
    logic [11:0]   dv;
    logic [5:0]    w;
    int            g;
    reset = rst;
    drive_inputs();
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus1.dest_push, bus1.dest_data, bus1.push_cnt} !== e) begin
        errors++;
        $display("FAIL dest_out t=%0t: got push=%b data=%h cnt=%h, exp push=%b data=%h cnt=%h",
                 $time, bus1.dest_push, bus1.dest_data, bus1.push_cnt, e[29:28], e[27:16], e[15:0]);
      end
    end
    elig = 2'b00;
    if (q0.size() > 0 && !af[q0[0][4]]) elig[0] = 1'b1;
    if (q1.size() > 0 && !af[q1[0][4]]) elig[1] = 1'b1;
    g = rst ? -1 : ref_grant(elig);
    exp_pop = (g >= 0) ? 2'(1 << g) : 2'b00;
    checks++;
    if (bus1.vc_pop !== exp_pop) begin
      errors++;
      $display("FAIL vc_pop t=%0t: got %b exp %b", $time, bus1.vc_pop, exp_pop);
    end
    if (bus1.vc_pop == 2'b01) gnt_log.push_back(0);
    else if (bus1.vc_pop == 2'b10) gnt_log.push_back(1);
    if (rst) begin
      m_owner = 0; m_vld = 1'b0; m_burst = 0; m_cnt0 = 8'd0; m_cnt1 = 8'd0;
      e = '0;
    end else if (g >= 0) begin
      w = (g == 0) ? q0.pop_front() : q1.pop_front();
      if (m_vld && g == m_owner) m_burst++;
      else m_burst = 0;
      m_owner = g;
      m_vld   = 1'b1;
      dv = 12'h000;
      if (w[4]) begin dv[11:6] = w; m_cnt1 = m_cnt1 + 8'd1; end
      else      begin dv[5:0]  = w; m_cnt0 = m_cnt0 + 8'd1; end
      e = {w[4] ? 2'b10 : 2'b01, dv, m_cnt1, m_cnt0};
    end else begin
      e = {2'b00, 12'h000, m_cnt1, m_cnt0};
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    af = 2'b00;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 1000) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d words left, exp 0", q0.size(), q1.size());
    end
    step(1'b0);
    step(1'b0);
  endtask

  task automatic test_reset();
    q0.push_back(6'h05);
    step(1'b1);
    step(1'b1);
    checks++;
    if ({bus1.dest_push, bus1.dest_data, bus1.push_cnt} !== '0 ||
        {bus0.dest_push, bus0.dest_data, bus0.push_cnt} !== '0 || bus0.vc_pop !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got bus1=%h bus0=%h pop0=%b, exp all 0",
               {bus1.dest_push, bus1.dest_data, bus1.push_cnt},
               {bus0.dest_push, bus0.dest_data, bus0.push_cnt}, bus0.vc_pop);
    end
    q0.delete();
    step(1'b0);
  endtask

  task automatic test_single_vc();
    q0.push_back(6'h05);
    q0.push_back(6'h06);
    drain();
    checks++;
    if (bus1.push_cnt[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL single_vc_cnt: got %0d exp 2", bus1.push_cnt[7:0]);
    end
  endtask

  task automatic test_burst_rr();
    int exp_seq[5];
    exp_seq = '{0, 0, 1, 1, 0};
    step(1'b1);
    gnt_log.delete();
    q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03);
    step(1'b0);
    q1.push_back(6'h08); q1.push_back(6'h09); q1.push_back(6'h0a);
    drain();
    checks++;
    if (gnt_log.size() < 5) begin
      errors++;
      $display("FAIL burst_len: got %0d grants exp at least 5", gnt_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gnt_log[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL burst_seq[%0d]: got VC%0d exp VC%0d", i, gnt_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    step(1'b1);
    q0.push_back(6'h15);
    q1.push_back(6'h03); q1.push_back(6'h04);
    af = 2'b10;
    step(1'b0);
    af = 2'b11;
    step(1'b0);
    af = 2'b10;
    step(1'b0);
    step(1'b0);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL bp_vc0_held: got %0d words left in VC0 exp 1", q0.size());
    end
    step(1'b0);
    af = 2'b00;
    step(1'b0);
    step(1'b0);
    checks++;
    if (bus1.push_cnt[15:8] !== 8'd1 || bus1.push_cnt[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL bp_counts: got d1=%0d d0=%0d exp d1=1 d0=2",
               bus1.push_cnt[15:8], bus1.push_cnt[7:0]);
    end
  endtask

  task automatic test_fixed_priority();
    logic [5:0] w0[$];
    logic [5:0] exp0_q[$];
    logic [1:0] exp_pop;
    logic [5:0] ew;
    w0 = '{6'h01, 6'h02, 6'h03};
    for (int c = 0; c < 6; c++) begin
      bus0.vc_empty = {1'b0, w0.size() == 0};
      bus0.vc_data  = {6'h0c, (w0.size() > 0) ? w0[0] : 6'h00};
      #1;
      if (exp0_q.size() > 0) begin
        ew = exp0_q.pop_front();
        checks++;
        if (bus0.dest_push !== 2'b01 || bus0.dest_data[5:0] !== ew) begin
          errors++;
          $display("FAIL fixed_out: got push=%b data=%h exp push=01 data=%h",
                   bus0.dest_push, bus0.dest_data[5:0], ew);
        end
      end
      exp_pop = (w0.size() > 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus0.vc_pop !== exp_pop) begin
        errors++;
        $display("FAIL fixed_pop c=%0d: got %b exp %b", c, bus0.vc_pop, exp_pop);
      end
      if (exp_pop == 2'b01) exp0_q.push_back(w0.pop_front());
      else exp0_q.push_back(6'h0c);
      @(posedge clk);
      @(negedge clk);
    end
    bus0.vc_empty = 2'b11;
    bus0.vc_data  = '0;
    #1;
    ew = exp0_q.pop_front();
    checks++;
    if (bus0.dest_push !== 2'b01 || bus0.dest_data[5:0] !== ew || bus0.push_cnt[7:0] !== 8'd6) begin
      errors++;
      $display("FAIL fixed_last: got push=%b data=%h cnt=%0d exp push=01 data=%h cnt=6",
               bus0.dest_push, bus0.dest_data[5:0], bus0.push_cnt[7:0], ew);
    end
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    step(1'b1);
    for (int i = 0; i < 256; i++) q0.push_back(6'($urandom_range(0, 63)) & 6'h2f);
    drain();
    checks++;
    if (bus1.push_cnt[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d exp 0", bus1.push_cnt[7:0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'h01 + 6'(i));
      q1.push_back(6'h21 + 6'(i));
    end
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    gnt_log.delete();
    step(1'b0);
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 1) begin
      errors++;
      $display("FAIL rst_mid_first: got %0d grants first=VC%0d exp 1 grant VC1",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
    drain();
  endtask

  task automatic test_random();
    step(1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && q0.size() < 6) q0.push_back(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) != 0 && q1.size() < 6) q1.push_back(6'($urandom_range(0, 63)));
      af = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step($urandom_range(0, 59) == 0);
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    af    = 2'b00;
    m_owner = 0; m_vld = 1'b0; m_burst = 0; m_cnt0 = 8'd0; m_cnt1 = 8'd0;
    drive_inputs();
    bus0.vc_data          = '0;
    bus0.vc_empty         = 2'b11;
    bus0.dest_almost_full = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_fixed_priority();
    test_single_vc();
    test_burst_rr();
    test_backpressure();
    test_counter_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_vc_rr.md
ARBITRO_VC_RR -- requirements
Module: arbitro_vc_rr

Interface
REQ-001 Parameter DATA_W, default 6, width of one word.
REQ-002 Parameter NUM_VC, default 2, number of virtual-channel input FIFOs (2..8).
REQ-003 Parameter NUM_DEST, default 2, number of destination FIFOs (power of 2, 2..4).
REQ-004 Parameter DEST_LSB, default 4, LSB of the destination field (log2(NUM_DEST) bits) inside a word.
REQ-005 Parameter MODE, default 1: 0 = fixed priority (VC0 highest), 1 = round robin with burst.
REQ-006 Parameter BURST, default 2, maximum consecutive grants to one VC in MODE 1 (1..15).
REQ-007 Parameter CNT_W, default 8, width of each per-destination push counter.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 vc_data  input  NUM_VC*DATA_W  head word of each VC FIFO (first-word-fall-through); VC i occupies bits [i*DATA_W +: DATA_W].
REQ-011 vc_empty  input  NUM_VC  per-VC empty flag.
REQ-012 dest_almost_full  input  NUM_DEST  per-destination back-pressure.
REQ-013 vc_pop  output  NUM_VC  combinational pop strobe, one-hot or zero.
REQ-014 dest_data  output  NUM_DEST*DATA_W  registered word for each destination.
REQ-015 dest_push  output  NUM_DEST  registered push strobe per destination.
REQ-016 push_cnt  output  NUM_DEST*CNT_W  registered count of words pushed per destination.

Function
REQ-017 dest(i) SHALL be vc_data word i bits [DEST_LSB +: log2(NUM_DEST)].
REQ-018 VC i SHALL be eligible when vc_empty[i]=0 and dest_almost_full[dest(i)]=0; a blocked VC SHALL NOT block other VCs.
REQ-019 MODE 0: grant SHALL go to the lowest-index eligible VC.
REQ-020 MODE 1: if owner VC is eligible and burst_cnt < BURST-1, grant SHALL stay on owner; otherwise grant SHALL go to the first eligible VC searching upward (wrapping) from owner+1, the owner itself last.
REQ-021 On a grant, owner SHALL take the granted index; burst_cnt SHALL increment if the index is unchanged, else load 0; with no grant, owner and burst_cnt SHALL hold.
REQ-022 vc_pop[g] SHALL assert in the grant cycle only; no grant -> vc_pop all zero.
REQ-023 At the edge ending a grant cycle, dest_data[dest(g)] SHALL load word g and dest_push[dest(g)] SHALL be 1; every other dest_data SHALL load 0 and dest_push 0 (1-cycle pop-to-push latency).
REQ-024 Cycles with no grant SHALL drive all dest_push 0 and all dest_data 0.
REQ-025 push_cnt[d] SHALL increment by 1 on each registered push to d, wrapping from 2^CNT_W-1 to 0.
REQ-026 At most one word SHALL be transferred per cycle.
REQ-027 dest_almost_full sampled in the grant cycle alone SHALL decide eligibility; a word already granted SHALL be pushed regardless of later almost_full.

Reset
REQ-028 While reset=1 at an edge: dest_data, dest_push, push_cnt, owner, burst_cnt SHALL be 0.
REQ-029 While reset=1, vc_pop SHALL be all zero regardless of inputs; a grant computed in that cycle SHALL be discarded.
REQ-030 Reset asserted mid-burst SHALL clear state so the first grant after release follows MODE 1 starting from owner=0.

Verification
REQ-031 Defaults, VC0 holds 0x05,0x06 (dest 0), VC1 empty -> pops on consecutive cycles, dest_push[0]=1 with 0x05 then 0x06 one cycle later, push_cnt[0]=2.
REQ-032 MODE 1, BURST=2, both VCs non-empty (dest 0) -> grant sequence VC0,VC0,VC1,VC1,VC0.
REQ-033 VC0 head 0x15 (dest 1) with dest_almost_full[1]=1, VC1 head 0x03 -> VC1 popped, dest_push[0]=1 with 0x03, VC0 not popped until almost_full clears.
REQ-034 MODE 0, both VCs continuously non-empty -> only VC0 popped until empty; VC1 popped the cycle VC0 goes empty.
REQ-035 CNT_W=8, 256 pushes to dest 0 -> push_cnt[0] returns to 0.
REQ-036 reset=1 for one cycle during active burst -> vc_pop=0 that cycle, all outputs 0 next cycle, next grant to lowest eligible index above owner 0 search (VC1 if eligible, else VC0).
